// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: records {seq, dest, pc, data} for every committed register
// write and presents it to a debug consumer over a valid/ready handshake.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic                     RegWrite,
  input  logic                     RegDst,
  input  logic [4:0]               rt_add,
  input  logic [4:0]               rd_add,
  input  logic [31:0]              instr_add_out,
  input  logic [31:0]              writeData_regFile,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [76:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [76:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    seq;
  logic [4:0]    dest;
  logic          cap_ev;
  logic          pop;
  logic          push;
  logic          drop;

  assign dest      = RegDst ? rd_add : rt_add;
  assign cap_ev    = cap_en & RegWrite & (dest != 5'd0);
  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = cap_ev & (~full | pop);
  assign drop      = cap_ev & full & ~pop;

  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Payload storage is never reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {seq, dest, instr_add_out, writeData_regFile};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= 8'd0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // seq advances on dropped events too so the consumer can see gaps.
      if (cap_ev) seq <= seq + 8'd1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
